// File: rtl/rmgmt_mem_pkg.sv
// rtl/rmgmt_mem_pkg.sv - shared types for the rmgmt memory responder
//
// Purpose : state encoding and byte-enable helpers used by the responder and
//           its optional alignment checker.
// Ports   : none (package).
package rmgmt_mem_pkg;

    localparam int unsigned BE_W = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CORE_XFER = 2'd1,
        RM_XFER   = 2'd2,
        RM_DONE   = 2'd3
    } rmgmt_mem_state_t;

    // Word access needs addr[1:0]==0; halfword access (either half) needs addr[0]==0.
    // Byte accesses and irregular enable patterns are never flagged.
    function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                           input logic [BE_W-1:0] byte_en);
        logic bad;
        bad = 1'b0;
        if (byte_en == 4'hF && addr_lo != 2'b00) begin
            bad = 1'b1;
        end
        if ((byte_en == 4'h3 || byte_en == 4'hC) && addr_lo[0]) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/rv32i_types_pkg.sv
// rtl/rv32i_types_pkg.sv - RV32I shared scalar types
//
// Purpose : machine word type shared by the core and its memory-side helpers.
// Ports   : none (package).
package rv32i_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/rmgmt_align_check.sv
// rtl/rmgmt_align_check.sv - extension access alignment detector
//
// Purpose : flags an extension access whose byte enables do not fit the
//           natural alignment of the address. Purely combinational.
// Ports   : addr_lo    in  2  low address bits of the extension request
//           byte_en    in  4  extension byte enables
//           misaligned out 1  access is misaligned
module rmgmt_align_check
    import rmgmt_mem_pkg::*;
(
    input  logic [1:0]      addr_lo,
    input  logic [BE_W-1:0] byte_en,
    output logic            misaligned
);

    assign misaligned = is_misaligned(addr_lo, byte_en);

endmodule

// File: rtl/rmgmt_mem_responder.sv
// rtl/rmgmt_mem_responder.sv - arbitrates extension and core data requests onto one bus
//
// Purpose : single-outstanding bus master shared by a pipeline extension
//           (rm_*) and the native core data port (core_*). The extension wins
//           ties; its result is held in RM_DONE until the pipeline advances so
//           a held request is never reissued.
// Optional: RMGMT_MEM_ALIGN_CHECK_EN adds the misaligned output and drops
//           misaligned extension requests without touching the bus.
// Ports   : CLK, nRST (async, active-low)
//           req_mem, rm_ren, rm_wen, rm_addr, rm_store, rm_byte_en -> mem_load, mem_busy
//           advance, ex_flush                 pipeline control
//           core_ren, core_wen, core_addr, core_wdata, core_byte_en -> core_rdata, core_busy
//           bus_ren, bus_wen, bus_addr, bus_wdata, bus_byte_en <- bus_rdata, bus_busy
//           misaligned (macro only)           one-cycle misaligned-request pulse
module rmgmt_mem_responder
    import rv32i_types_pkg::*;
    import rmgmt_mem_pkg::*;
(
    input  logic            CLK,
    input  logic            nRST,
    input  logic            req_mem,
    input  logic            rm_ren,
    input  logic            rm_wen,
    input  word_t           rm_addr,
    input  word_t           rm_store,
    input  logic [BE_W-1:0] rm_byte_en,
    output word_t           mem_load,
    output logic            mem_busy,
    input  logic            advance,
    input  logic            ex_flush,
    input  logic            core_ren,
    input  logic            core_wen,
    input  word_t           core_addr,
    input  word_t           core_wdata,
    input  logic [BE_W-1:0] core_byte_en,
    output word_t           core_rdata,
    output logic            core_busy,
    output logic            bus_ren,
    output logic            bus_wen,
    output word_t           bus_addr,
    output word_t           bus_wdata,
    output logic [BE_W-1:0] bus_byte_en,
    input  word_t           bus_rdata,
    input  logic            bus_busy
`ifdef RMGMT_MEM_ALIGN_CHECK_EN
    ,
    output logic            misaligned
`endif
);

    rmgmt_mem_state_t state_q, state_d;

    word_t           addr_q, wdata_q, mem_load_q, core_rdata_q;
    logic [BE_W-1:0] be_q;
    logic            ren_q, wen_q;
    logic            flush_q;
    logic            capture_rm, capture_core;

    logic rm_req, core_req, in_xfer, core_done, rm_done, rm_bad, rm_flushed;

    assign rm_req     = req_mem & (rm_ren | rm_wen);
    assign core_req   = core_ren | core_wen;
    assign in_xfer    = (state_q == CORE_XFER) || (state_q == RM_XFER);
    assign core_done  = (state_q == CORE_XFER) && !bus_busy;
    assign rm_done    = (state_q == RM_XFER) && !bus_busy;
    // A flush seen at any point of the transfer (including its last cycle) discards it.
    assign rm_flushed = flush_q | ex_flush;

`ifdef RMGMT_MEM_ALIGN_CHECK_EN
    logic mis_q;

    rmgmt_align_check u_align_check (
        .addr_lo    (rm_addr[1:0]),
        .byte_en    (rm_byte_en),
        .misaligned (rm_bad)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= (state_q == IDLE) && rm_req && rm_bad;
        end
    end

    assign misaligned = mis_q;
`else
    assign rm_bad = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        capture_rm   = 1'b0;
        capture_core = 1'b0;
        case (state_q)
            IDLE: begin
                if (rm_req) begin
                    if (rm_bad) begin
                        state_d = RM_DONE;
                    end else begin
                        state_d    = RM_XFER;
                        capture_rm = 1'b1;
                    end
                end else if (core_req) begin
                    state_d      = CORE_XFER;
                    capture_core = 1'b1;
                end
            end
            CORE_XFER: begin
                if (!bus_busy) begin
                    state_d = IDLE;
                end
            end
            RM_XFER: begin
                if (!bus_busy) begin
                    state_d = rm_flushed ? IDLE : RM_DONE;
                end
            end
            RM_DONE: begin
                if (advance || !req_mem || ex_flush) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            ren_q        <= 1'b0;
            wen_q        <= 1'b0;
            flush_q      <= 1'b0;
            mem_load_q   <= '0;
            core_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture_rm) begin
                addr_q  <= rm_addr;
                wdata_q <= rm_store;
                be_q    <= rm_byte_en;
                // Read+write together is a write.
                ren_q   <= rm_ren & ~rm_wen;
                wen_q   <= rm_wen;
            end else if (capture_core) begin
                addr_q  <= core_addr;
                wdata_q <= core_wdata;
                be_q    <= core_byte_en;
                ren_q   <= core_ren & ~core_wen;
                wen_q   <= core_wen;
            end
            if (state_q == RM_XFER && state_d == RM_XFER) begin
                flush_q <= flush_q | ex_flush;
            end else begin
                flush_q <= 1'b0;
            end
            if (rm_done && !rm_flushed && ren_q) begin
                mem_load_q <= bus_rdata;
            end
            if (core_done) begin
                core_rdata_q <= bus_rdata;
            end
        end
    end

    assign bus_ren     = in_xfer & ren_q;
    assign bus_wen     = in_xfer & wen_q;
    assign bus_addr    = addr_q;
    assign bus_wdata   = wdata_q;
    assign bus_byte_en = be_q;

    assign mem_load   = mem_load_q;
    // The core sees its read data in the completion cycle itself.
    assign core_rdata = core_done ? bus_rdata : core_rdata_q;
    assign core_busy  = core_req && !core_done;
    assign mem_busy   = rm_req && (state_q != RM_DONE) && !rm_done;

endmodule

// File: doc/rmgmt_mem_responder.md
RMGMT_MEM_RESPONDER -- requirements
Module: rmgmt_mem_responder

Interface
REQ-001 CLK  in  1  core clock; all state updates on rising edge.
REQ-002 nRST  in  1  reset, asynchronous, active-low.
REQ-003 req_mem, rm_ren, rm_wen  in  1 each  extension memory claim, read strobe and write strobe.
REQ-004 rm_addr, rm_store  in  32 each  extension address and store data; rm_byte_en  in  4  extension byte enables.
REQ-005 mem_load  out  32  load data returned to the extension; mem_busy  out  1  extension access pending.
REQ-006 advance  in  1  pipeline advance (IF/EX enable); ex_flush  in  1  pipeline flush.
REQ-007 core_ren, core_wen  in  1 each; core_addr, core_wdata  in  32 each; core_byte_en  in  4  native core data request.
REQ-008 core_rdata  out  32; core_busy  out  1  native core data response.
REQ-009 bus_ren, bus_wen  out  1 each; bus_addr, bus_wdata  out  32 each; bus_byte_en  out  4  generic bus request.
REQ-010 bus_rdata  in  32; bus_busy  in  1  generic bus response; a transfer completes in the first cycle bus_busy==0 while a strobe is high.

Function
REQ-011 The FSM SHALL have four states: IDLE, CORE_XFER, RM_XFER, RM_DONE.
REQ-012 IDLE: if req_mem && (rm_ren|rm_wen), go to RM_XFER; else if core_ren|core_wen, go to CORE_XFER. The extension SHALL win simultaneous requests.
REQ-013 On leaving IDLE, the block SHALL register address, write data, byte enables and the ren/wen pair of the winner. Bus outputs SHALL come only from these registers; the bus is first driven the cycle after the request.
REQ-014 rm_ren&&rm_wen both high SHALL be treated as a write.
REQ-015 CORE_XFER: on completion, core_rdata SHALL equal bus_rdata and the state SHALL return to IDLE.
REQ-016 core_busy SHALL be 1 whenever (core_ren|core_wen) is high and the cycle is not the core completion cycle.
REQ-017 RM_XFER: on completion, mem_load SHALL capture bus_rdata (reads only) and hold it until the next extension read completes. The state SHALL go to RM_DONE.
REQ-018 mem_busy SHALL be 1 whenever req_mem&&(rm_ren|rm_wen) is high, unless the state is RM_DONE or the cycle is the extension completion cycle.
REQ-019 RM_DONE SHALL issue no bus strobes. It SHALL go to IDLE when advance==1 or req_mem==0, so a held request is never reissued.
REQ-020 ex_flush in RM_XFER SHALL NOT drop the bus strobes before completion. The completion SHALL be discarded: mem_load is unchanged and the state goes to IDLE.
REQ-021 ex_flush in RM_DONE SHALL force IDLE. ex_flush SHALL NOT affect CORE_XFER.
REQ-022 The block SHALL have a maximum of one outstanding bus transfer. Bus strobes SHALL be low in IDLE and RM_DONE.

Reset
REQ-023 nRST low SHALL immediately set: state IDLE, all bus strobes 0, mem_busy/core_busy computed from inputs as in IDLE, mem_load 0, core_rdata 0, captured registers 0.
REQ-024 Reset mid-transfer SHALL abandon the transfer; the bus owner tolerates strobe drop.

Configuration
REQ-025 With RMGMT_MEM_ALIGN_CHECK_EN defined, an output misaligned (1 bit) SHALL exist.
- Trigger: an extension request with rm_byte_en==4'hF and rm_addr[1:0]!=0, or rm_byte_en 4'h3/4'hC with rm_addr[0]!=0.
- Response: the request is not issued to the bus; misaligned pulses high for one cycle; the state goes IDLE->RM_DONE directly.
REQ-026 Without RMGMT_MEM_ALIGN_CHECK_EN, the port SHALL be absent and all extension requests SHALL be issued unchanged.

Structure
REQ-027 word_t SHALL come from rv32i_types_pkg. The state enum rmgmt_mem_state_t SHALL live in a shared rmgmt_mem_pkg.
REQ-028 The alignment check SHALL be an optional sub-module rmgmt_align_check, instantiated only under the macro. No other sub-modules.

Verification
REQ-029 Extension read, addr 0x100, bus_busy high 2 cycles, bus_rdata 0xDEADBEEF -> bus_ren high cycles 1-3; mem_busy 1 until completion; mem_load=0xDEADBEEF; RM_DONE until advance.
REQ-030 Simultaneous core write 0x200 and extension read 0x300 -> extension served first with core_busy=1 throughout; core write to 0x200 issued after RM_DONE exits.
REQ-031 req_mem held 5 cycles after completion with advance=0 -> exactly one bus transfer; mem_busy=0 in RM_DONE.
REQ-032 ex_flush during extension read with bus_busy high -> strobes held until completion; mem_load unchanged; state IDLE next cycle.
REQ-033 nRST asserted mid RM_XFER -> bus strobes 0 same cycle; mem_load 0; next request served normally.
REQ-034 Macro on, rm_addr 0x102 with byte_en 4'hF -> no bus strobe; misaligned=1 for one cycle; mem_busy=0 next cycle.
